// File: rtl/ascii_hex_pkg.sv
// Shared types and character constants for the ASCII hex word parser.
package ascii_hex_pkg;

    // Parser states: no digits yet, collecting digits, word presented.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    // Characters that terminate a word.
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] SP    = 8'h20;
    localparam logic [7:0] COMMA = 8'h2C;

endpackage

// File: rtl/ascii_hex_decode.sv
// Combinational classifier: maps one ASCII character to a hex nibble and
// flags whether it is a digit, a word delimiter, or neither.
module ascii_hex_decode
    import ascii_hex_pkg::*;
#(
    parameter bit LOWER_EN = 1'b1
) (
    input  logic [7:0] char_i,
    output logic [3:0] nibble_o,
    output logic       is_digit_o,
    output logic       is_delim_o
);

    // Range checks on the character code; letters map via low nibble + 9.
    always_comb begin
        nibble_o   = 4'd0;
        is_digit_o = 1'b0;
        is_delim_o = 1'b0;
        if (char_i >= 8'h30 && char_i <= 8'h39) begin
            is_digit_o = 1'b1;
            nibble_o   = char_i[3:0];
        end else if (char_i >= 8'h41 && char_i <= 8'h46) begin
            is_digit_o = 1'b1;
            nibble_o   = char_i[3:0] + 4'd9;
        end else if (LOWER_EN && char_i >= 8'h61 && char_i <= 8'h66) begin
            is_digit_o = 1'b1;
            nibble_o   = char_i[3:0] + 4'd9;
        end else if (char_i == CR || char_i == LF || char_i == SP || char_i == COMMA) begin
            is_delim_o = 1'b1;
        end
    end

endmodule

// File: rtl/ascii_hex_parser.sv
// Assembles a stream of ASCII hex characters into right-justified words.
// A word ends on a delimiter or when DIGITS digits have been collected; it is
// then held on the output until the consumer takes it. Invalid characters
// discard the partial word and raise a one-cycle err pulse.
module ascii_hex_parser
    import ascii_hex_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter bit LOWER_EN = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [4*DIGITS-1:0]          out_word,
    output logic [$clog2(DIGITS+1)-1:0]  out_count,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         err
);

    localparam int WW = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    state_e          state_q;
    logic [WW-1:0]   word_q;
    logic [CW-1:0]   count_q;
    logic            err_q;

    logic [3:0]      nibble;
    logic            is_digit;
    logic            is_delim;
    logic [WW-1:0]   word_shift_d;

    ascii_hex_decode #(
        .LOWER_EN (LOWER_EN)
    ) u_decode (
        .char_i     (in_data),
        .nibble_o   (nibble),
        .is_digit_o (is_digit),
        .is_delim_o (is_delim)
    );

    // Word with the incoming nibble appended as the least significant digit.
    always_comb begin
        word_shift_d      = word_q << 4;
        word_shift_d[3:0] = nibble;
    end

    // Main state machine; every transfer is classified and acted on here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_ACCUM: begin
                    if (in_valid) begin
                        if (is_digit) begin
                            word_q  <= word_shift_d;
                            count_q <= count_q + CW'(1);
                            // The digit that fills the word also closes it.
                            state_q <= (count_q == CW'(DIGITS - 1)) ? ST_HOLD : ST_ACCUM;
                        end else if (is_delim) begin
                            // A delimiter with nothing collected is ignored.
                            if (state_q == ST_ACCUM) begin
                                state_q <= ST_HOLD;
                            end
                        end else begin
                            word_q  <= '0;
                            count_q <= '0;
                            state_q <= ST_IDLE;
                            err_q   <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        word_q  <= '0;
                        count_q <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    word_q  <= '0;
                    count_q <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake and output decode from registered state only.
    assign out_valid = (state_q == ST_HOLD);
    assign in_ready  = (state_q != ST_HOLD);
    assign out_word  = out_valid ? word_q : '0;
    assign out_count = out_valid ? count_q : '0;
    assign err       = err_q;

endmodule

// File: doc/ascii_hex_parser.md
ASCII_HEX_PARSER -- requirements
Module: ascii_hex_parser

Interface
REQ-001 SHALL have parameter DIGITS, default 8, meaning maximum hex digits per word (legal range 1..16).
REQ-002 SHALL have parameter LOWER_EN, default 1, meaning lowercase 'a'-'f' (0x61-0x66) are accepted as digits when 1.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-005 SHALL have port in_data, input, 8 bits, the ASCII character from the UART receiver.
REQ-006 SHALL have port in_valid, input, 1 bit, meaning in_data is valid.
REQ-007 SHALL have port in_ready, output, 1 bit, meaning the parser accepts in_data this cycle.
REQ-008 SHALL have port out_word, output, 4*DIGITS bits, the assembled value, right-justified and zero-extended.
REQ-009 SHALL have port out_count, output, $clog2(DIGITS+1) bits, the number of digits in out_word.
REQ-010 SHALL have port out_valid, output, 1 bit, meaning out_word/out_count are valid.
REQ-011 SHALL have port out_ready, input, 1 bit, meaning the consumer takes the word.
REQ-012 SHALL have port err, output, 1 bit, a one-cycle pulse flagging an invalid character.

Function
REQ-013 SHALL accept a character only on a cycle where in_valid && in_ready (transfer).
REQ-014 SHALL classify each transferred character as: digit ('0'-'9', 'A'-'F', and 'a'-'f' if LOWER_EN), delimiter (0x0D, 0x0A, 0x20, 0x2C), or invalid (everything else, including lowercase when LOWER_EN=0).
REQ-015 SHALL implement the states IDLE (count=0), ACCUM (0<count<DIGITS) and HOLD (out_valid=1).
REQ-016 On a digit transfer, SHALL shift the word left by 4, insert the nibble at bits [3:0], and increment count.
REQ-017 When a digit transfer makes count==DIGITS, SHALL enter HOLD, with out_valid asserted the next cycle.
REQ-018 On a delimiter in ACCUM, SHALL enter HOLD; on a delimiter in IDLE, SHALL ignore it (no output, no err).
REQ-019 On an invalid character in IDLE or ACCUM, SHALL clear the word and count, return to IDLE, and pulse err for exactly one cycle, starting the cycle after the transfer.
REQ-020 SHALL drive in_ready = 1 in IDLE and ACCUM and 0 in HOLD, decoded from registered state only.
REQ-021 In HOLD, SHALL keep out_valid, out_word and out_count stable until out_ready=1.
REQ-022 On out_valid && out_ready, SHALL clear the word and count and enter IDLE on the next cycle; an input transfer cannot occur in that same cycle.
REQ-023 Latency: the final digit or delimiter transferred in cycle N SHALL give out_valid=1 in cycle N+1.
REQ-024 Back-to-back: with out_ready held at 1, SHALL sustain one word per (digits+1) cycles, plus 1 cycle when a delimiter terminates the word.
REQ-025 SHALL drive out_word and out_count to 0 whenever out_valid=0.

Reset
REQ-026 On rst=1, SHALL immediately (asynchronously) force state=IDLE, word=0, count=0, out_valid=0, err=0, in_ready=1.
REQ-027 Reset asserted mid-word or in HOLD SHALL discard the partial or pending word without emitting it.
REQ-028 After rst deasserts, the first transfer SHALL be accepted on the first rising edge.

Structure
REQ-029 Package ascii_hex_pkg SHALL hold the state enum and the delimiter constants (CR, LF, SP, COMMA).
REQ-030 SHALL instantiate one combinational sub-module, ascii_hex_decode (in: 8-bit char, LOWER_EN; out: 4-bit nibble, is_digit, is_delim).
REQ-031 Estimated RTL size: 150-250 lines in total.

Verification
REQ-032 Feed "1A2b\r" with DIGITS=8, LOWER_EN=1, out_ready=1 -> out_word=0x00001A2B, out_count=4, single out_valid pulse, err=0.
REQ-033 Feed "DEADBEEF" with DIGITS=8 and out_ready=0 for 5 cycles -> out_valid=1 the cycle after 'F', in_ready=0, word 0xDEADBEEF held stable, cleared after out_ready.
REQ-034 Feed "12G3\n" -> err pulses 1 cycle after 'G', no output for "12", then out_word=0x3 with out_count=1.
REQ-035 Feed "  ,\r" with no digits -> no out_valid, no err, in_ready=1 throughout.
REQ-036 Assert rst after "AB" and before the delimiter, then feed "C " -> out_word=0xC with out_count=1; AB is never emitted.
REQ-037 Feed "ab " with LOWER_EN=0 -> err pulses after 'a' and after 'b'; no out_valid.
